// File: rtl/seq_scan_pkg.sv
// Shared types and helpers for the serial pattern-scan arbiter.
// The detector's overlap fallback is derived here from the pattern itself.
package seq_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int MAX_PAT_W = 16;
    localparam int DEF_PAT_W = 4;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 4'b1011;

    // Matched-prefix length after seeing bit b with s bits already matched.
    // Result is always a proper prefix (< pw), so a full match falls back
    // to the longest prefix that is also a suffix.
    function automatic int next_len(input logic [MAX_PAT_W-1:0] pat, input int pw,
                                    input int s, input logic b);
        int best;
        int idx;
        logic ok;
        logic sb;
        logic [MAX_PAT_W-1:0] t;
        best = 0;
        for (int k = 1; k < MAX_PAT_W; k++) begin
            if (k < pw && k <= s + 1) begin
                ok = 1'b1;
                for (int j = 0; j < MAX_PAT_W; j++) begin
                    if (j < k) begin
                        idx = s + 1 - k + j;
                        t   = pat >> (pw - 1 - idx);
                        sb  = (idx == s) ? b : t[0];
                        t   = pat >> (pw - 1 - j);
                        if (sb != t[0]) ok = 1'b0;
                    end
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_scan_arbiter_det.sv
// Mealy detector: state is the matched-prefix length, dec fires on the
// bit completing the pattern.
module mealy_pattern_detector
    import seq_scan_pkg::*;
#(
    parameter int                PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0]  PATTERN = DEF_PATTERN
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in,
    output logic dec
);

    localparam int SW = $clog2(PAT_W);

    logic [SW-1:0] state;
    logic [SW-1:0] nxt;

    always_comb begin
        nxt = SW'(next_len(MAX_PAT_W'(PATTERN), PAT_W, int'(state), in));
        dec = (int'(state) == PAT_W - 1) && (in == PATTERN[0]);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) state <= '0;
        else            state <= nxt;
    end

endmodule

// File: rtl/seq_scan_arbiter.sv
// Round-robin front end that serialises one requester word at a time,
// MSB first, through a shared pattern detector and reports the match count.
module seq_scan_arbiter
    import seq_scan_pkg::*;
#(
    parameter int               NUM_REQ = 4,
    parameter int               WORD_W  = 8,
    parameter int               PAT_W   = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WORD_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       res_valid,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic [$clog2(WORD_W+1)-1:0] res_count,
    input  logic                       res_ready,
    output logic                       busy,
    output logic                       det_in,
    output logic                       det_dec
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(WORD_W + 1);
    localparam int BW = $clog2(WORD_W);

    state_t              state;
    logic [IW-1:0]       rr_ptr;
    logic [IW-1:0]       grant_id;
    logic [IW-1:0]       cand;
    logic                found;
    logic                accept;
    logic [WORD_W-1:0]   sreg;
    logic [BW-1:0]       bcnt;
    logic [CW-1:0]       cnt;
    logic                dec_raw;

    // First valid requester strictly after rr_ptr, wrapping around.
    always_comb begin
        grant_id = '0;
        cand     = '0;
        found    = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((int'(rr_ptr) + i) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found    = 1'b1;
                grant_id = cand;
            end
        end
    end

    always_comb begin
        accept    = (state == IDLE) && found && !rst;
        req_ready = '0;
        if (accept) req_ready[grant_id] = 1'b1;
        det_in  = (state == SHIFT) && sreg[WORD_W-1];
        det_dec = (state == SHIFT) && dec_raw;
    end

    mealy_pattern_detector #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_det (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .in  (det_in),
        .dec (dec_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= IW'(NUM_REQ - 1);
            sreg      <= '0;
            bcnt      <= '0;
            cnt       <= '0;
            res_valid <= 1'b0;
            res_id    <= '0;
            res_count <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg   <= req_data[grant_id*WORD_W +: WORD_W];
                        rr_ptr <= grant_id;
                        bcnt   <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg <= sreg << 1;
                    bcnt <= bcnt + BW'(1);
                    if (det_dec) cnt <= cnt + CW'(1);
                    // The last bit's detection is folded straight into the result.
                    if (bcnt == BW'(WORD_W - 1)) begin
                        res_valid <= 1'b1;
                        res_id    <= rr_ptr;
                        res_count <= cnt + CW'(det_dec);
                        state     <= REPORT;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Directed self-checking bench for seq_scan_arbiter (4 requesters, 8-bit words,
// pattern 1011).
module tb_seq_scan_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        res_valid;
    logic [1:0]  res_id;
    logic [3:0]  res_count;
    logic        res_ready;
    logic        busy;
    logic        det_in;
    logic        det_dec;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seq_scan_arbiter #(
        .NUM_REQ (4),
        .WORD_W  (8),
        .PAT_W   (4),
        .PATTERN (4'b1011)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_id    (res_id),
        .res_count (res_count),
        .res_ready (res_ready),
        .busy      (busy),
        .det_in    (det_in),
        .det_dec   (det_dec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus only: submit one word from an idle start and record what is seen.
    task automatic run_word(input int id, input logic [7:0] w,
                            output logic [3:0] gnt, output logic [7:0] bits,
                            output logic [7:0] decs, output logic rv,
                            output logic [1:0] rid, output logic [3:0] rcnt,
                            output logic idle_after);
        logic early;
        early     = 1'b0;
        res_ready = 1'b1;
        req_data[id*8 +: 8] = w;
        req_valid = 4'b0001 << id;
        #1 gnt = req_ready;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) req_valid = 4'b0000;
            bits[7-k] = det_in;
            decs[k]   = det_dec;
            early     = early | res_valid;
        end
        @(negedge clk);
        rv   = res_valid && !early;
        rid  = res_id;
        rcnt = res_count;
        @(negedge clk);
        idle_after = !res_valid && !busy;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 4'b1111; req_data = '0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        checks++;
        if ({busy, res_valid, det_in, det_dec} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: busy/res_valid/det_in/det_dec got %b expected 0000",
                               {busy, res_valid, det_in, det_dec});
        end
        checks++;
        if ({res_id, res_count} !== 6'b0) begin
            errors++; $display("FAIL reset_result: id %0d count %0d expected 0 0", res_id, res_count);
        end
        rst = 1'b0; req_valid = 4'b0000; res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_basic;
        logic [3:0] g; logic [7:0] b, d; logic rv, ia; logic [1:0] id; logic [3:0] c;
        run_word(0, 8'b1011_0110, g, b, d, rv, id, c, ia);
        checks++;
        if (g !== 4'b0001) begin errors++; $display("FAIL basic_grant: got %b expected 0001", g); end
        checks++;
        if (b !== 8'b1011_0110) begin errors++; $display("FAIL basic_bits: got %b expected 10110110", b); end
        checks++;
        if (d !== 8'b0100_1000) begin errors++; $display("FAIL basic_dec: got %b expected 01001000", d); end
        checks++;
        if (rv !== 1'b1) begin errors++; $display("FAIL basic_latency: res_valid at A+9 got %b expected 1", rv); end
        checks++;
        if (id !== 2'd0 || c !== 4'd2) begin
            errors++; $display("FAIL basic_result: id %0d count %0d expected 0 2", id, c);
        end
        checks++;
        if (ia !== 1'b1) begin errors++; $display("FAIL basic_release: idle after handshake got %b expected 1", ia); end
    endtask

    task automatic test_counts;
        logic [3:0] g; logic [7:0] b, d; logic rv, ia; logic [1:0] id; logic [3:0] c;
        run_word(3, 8'b1010_1010, g, b, d, rv, id, c, ia);
        checks++;
        if (rv !== 1'b1 || id !== 2'd3 || c !== 4'd0 || d !== 8'b0) begin
            errors++; $display("FAIL count_zero: valid %b id %0d count %0d dec %b expected 1 3 0 00000000",
                               rv, id, c, d);
        end
        run_word(3, 8'b1011_1011, g, b, d, rv, id, c, ia);
        checks++;
        if (rv !== 1'b1 || id !== 2'd3 || c !== 4'd2) begin
            errors++; $display("FAIL count_overlap: valid %b id %0d count %0d expected 1 3 2", rv, id, c);
        end
        checks++;
        if (d !== 8'b1000_1000) begin errors++; $display("FAIL overlap_dec: got %b expected 10001000", d); end
    endtask

    task automatic test_rotation;
        int gid[$]; int gcy[$]; int rid[$]; int rcn[$]; int rcy[$];
        int exp_cnt[4];
        logic drop;
        exp_cnt[0] = 2; exp_cnt[1] = 2; exp_cnt[2] = 1; exp_cnt[3] = 0;
        drop = 1'b0;
        res_ready = 1'b1;
        req_data  = {8'b1010_1010, 8'b0000_1011, 8'b1011_1011, 8'b1011_0110};
        req_valid = 4'b1111;
        for (int n = 0; n < 80 && rid.size() < 5; n++) begin
            #1;
            if (req_ready != 4'b0000) begin
                for (int i = 0; i < 4; i++) if (req_ready[i]) gid.push_back(i);
                gcy.push_back(cyc);
                if (gid.size() == 5) drop = 1'b1;
            end
            if (res_valid && res_ready) begin
                rid.push_back(int'(res_id)); rcn.push_back(int'(res_count)); rcy.push_back(cyc);
            end
            @(negedge clk);
            if (drop) req_valid = 4'b0000;
        end
        req_valid = 4'b0000;
        checks++;
        if (gid.size() != 5 || rid.size() != 5) begin
            errors++; $display("FAIL rotation_volume: grants %0d results %0d expected 5 5", gid.size(), rid.size());
        end
        for (int i = 0; i < gid.size(); i++) begin
            checks++;
            if (gid[i] != i % 4) begin
                errors++; $display("FAIL rotation_order: grant %0d went to %0d expected %0d", i, gid[i], i % 4);
            end
            if (i > 0) begin
                checks++;
                if (gcy[i] - gcy[i-1] != 10) begin
                    errors++; $display("FAIL rotation_spacing: grant %0d gap %0d expected 10", i, gcy[i] - gcy[i-1]);
                end
            end
        end
        for (int i = 0; i < rid.size(); i++) begin
            checks++;
            if (rid[i] != i % 4 || rcn[i] != exp_cnt[i % 4]) begin
                errors++; $display("FAIL rotation_result: result %0d id %0d count %0d expected %0d %0d",
                                   i, rid[i], rcn[i], i % 4, exp_cnt[i % 4]);
            end
            if (i > 0) begin
                checks++;
                if (rcy[i] - rcy[i-1] != 10) begin
                    errors++; $display("FAIL result_spacing: result %0d gap %0d expected 10", i, rcy[i] - rcy[i-1]);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] g; logic [7:0] b, d; logic rv, ia; logic [1:0] id; logic [3:0] c;
        run_word(2, 8'b0000_0101, g, b, d, rv, id, c, ia);
        checks++;
        if (g !== 4'b0100 || rv !== 1'b1 || id !== 2'd2 || c !== 4'd0) begin
            errors++; $display("FAIL b2b_first: grant %b valid %b id %0d count %0d expected 0100 1 2 0", g, rv, id, c);
        end
        run_word(2, 8'b1000_0000, g, b, d, rv, id, c, ia);
        checks++;
        if (g !== 4'b0100 || rv !== 1'b1 || id !== 2'd2 || c !== 4'd0 || d !== 8'b0) begin
            errors++; $display("FAIL b2b_no_cross: grant %b valid %b id %0d count %0d dec %b expected 0100 1 2 0 00000000",
                               g, rv, id, c, d);
        end
    endtask

    task automatic test_stall;
        res_ready = 1'b0;
        req_data[7:0] = 8'b1011_0110;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (8) @(negedge clk);
        req_data[15:8] = 8'b1011_0000;
        req_valid = 4'b0010;
        for (int n = 0; n < 5; n++) begin
            #1;
            checks++;
            if (res_valid !== 1'b1 || res_id !== 2'd0 || res_count !== 4'd2 || busy !== 1'b1 || req_ready !== 4'b0000) begin
                errors++; $display("FAIL stall_hold: cycle %0d valid %b id %0d count %0d busy %b ready %b expected 1 0 2 1 0000",
                                   n, res_valid, res_id, res_count, busy, req_ready);
            end
            @(negedge clk);
        end
        res_ready = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0010 || res_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release: ready %b valid %b expected 0010 0", req_ready, res_valid);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (8) @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd1 || res_count !== 4'd1) begin
            errors++; $display("FAIL stall_next: valid %b id %0d count %0d expected 1 1 1", res_valid, res_id, res_count);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int stray;
        stray = 0;
        res_ready = 1'b1;
        req_data[23:16] = 8'b1011_1011;
        req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 4'b0000 || det_in !== 1'b0) begin
            errors++; $display("FAIL midreset_state: busy %b valid %b ready %b det_in %b expected 0 0 0000 0",
                               busy, res_valid, req_ready, det_in);
        end
        rst = 1'b0;
        req_data  = {8'b1111_1111, 8'b1011_1011, 8'b1011_0110, 8'b0000_1011};
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL midreset_priority: ready %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = 4'b0000;
        for (int k = 0; k < 8; k++) begin
            if (res_valid) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray != 0) begin
            errors++; $display("FAIL midreset_stray: %0d early result cycles expected 0", stray);
        end
        checks++;
        if (res_valid !== 1'b1 || res_id !== 2'd0 || res_count !== 4'd1) begin
            errors++; $display("FAIL midreset_next: valid %b id %0d count %0d expected 1 0 1", res_valid, res_id, res_count);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_counts();
        test_rotation();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
